// File: rtl/cpu1_pkg.sv
// cpu1_pkg: opcode map, sequencer state codes and instruction field layout for CPU1.
package cpu1_pkg;

  // Instruction layout: {opcode[OPC_W-1:0], operand[W-1:0]}
  localparam int unsigned OPC_W = 4;
  localparam int unsigned OPND_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUBI = 4'h3;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h4;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'h5;
  localparam logic [OPC_W-1:0] OP_JC   = 4'h6;
  localparam logic [OPC_W-1:0] OP_OUT  = 4'h7;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'h8;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] FETCH = 2'd0;
  localparam logic [ST_W-1:0] EXEC  = 2'd1;
  localparam logic [ST_W-1:0] HALT  = 2'd2;

endpackage

// File: rtl/cpu1_ctrl_if.sv
// cpu1_ctrl_if: program-store / PC / output bundle of the CPU1 controller.
// master = the controller, slave = the surrounding PC/program store.
interface cpu1_ctrl_if
  import cpu1_pkg::*;
#(
  parameter int unsigned W = 4
);
  logic                 run_i;
  logic [W+OPC_W-1:0]   instr_i;
  logic                 pc_adv_o;
  logic                 pc_jump_o;
  logic [W-1:0]         pc_jump_v_o;
  logic [W-1:0]         acc_o;
  logic                 z_o;
  logic                 c_o;
  logic [W-1:0]         out_o;
  logic                 out_valid_o;
  logic                 halted_o;
  logic                 illegal_o;

  modport master (
    input  run_i, instr_i,
    output pc_adv_o, pc_jump_o, pc_jump_v_o, acc_o, z_o, c_o,
           out_o, out_valid_o, halted_o, illegal_o
  );

  modport slave (
    output run_i, instr_i,
    input  pc_adv_o, pc_jump_o, pc_jump_v_o, acc_o, z_o, c_o,
           out_o, out_valid_o, halted_o, illegal_o
  );
endinterface

// File: rtl/cpu1_alu.sv
// cpu1_alu: combinational LDI/ADDI/SUBI datapath; other opcodes pass state through.
module cpu1_alu
  import cpu1_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [OPC_W-1:0] i_op,
  input  logic [W-1:0]     i_acc,
  input  logic [W-1:0]     i_imm,
  input  logic             i_z,
  input  logic             i_c,
  output logic [W-1:0]     o_acc_c,
  output logic             o_z_c,
  output logic             o_c_c
);
  localparam int unsigned SW = W + 1;

  logic [SW-1:0] w_sum;

  // Result, zero and carry/borrow; the extra top bit of w_sum is carry on add, borrow on sub
  always_comb begin
    o_acc_c = i_acc;
    o_z_c   = i_z;
    o_c_c   = i_c;
    w_sum   = '0;
    case (i_op)
      OP_LDI: begin
        o_acc_c = i_imm;
        o_z_c   = (i_imm == '0);
      end
      OP_ADDI: begin
        w_sum   = SW'(i_acc) + SW'(i_imm);
        o_acc_c = w_sum[W-1:0];
        o_c_c   = w_sum[W];
        o_z_c   = (w_sum[W-1:0] == '0);
      end
      OP_SUBI: begin
        w_sum   = SW'(i_acc) - SW'(i_imm);
        o_acc_c = w_sum[W-1:0];
        o_c_c   = w_sum[W];
        o_z_c   = (w_sum[W-1:0] == '0);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/cpu1_ctrl.sv
// cpu1_ctrl: FETCH/EXEC/HALT sequencer for CPU1 with accumulator, Z/C flags and output port.
// Optional build macro CPU1_ILLEGAL_TRAP_EN: reserved opcodes halt and raise illegal_o;
// otherwise they behave as NOP and illegal_o is 0.
module cpu1_ctrl
  import cpu1_pkg::*;
#(
  parameter int unsigned W            = 4,
  parameter bit          RESET_HALTED = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  cpu1_ctrl_if.master bus
);
  logic [ST_W-1:0]    r_state;
  logic [ST_W-1:0]    w_state_nxt;
  logic [W+OPC_W-1:0] r_ir;
  logic [W-1:0]       r_acc;
  logic               r_z;
  logic               r_c;
  logic [W-1:0]       r_out;
  logic               r_out_valid;

  logic [OPC_W-1:0]   w_op;
  logic [W-1:0]       w_imm;
  logic               w_ir_load;
  logic               w_pc_adv;
  logic               w_pc_jump;
  logic [W-1:0]       w_pc_jump_v;
  logic [W-1:0]       w_alu_acc;
  logic               w_alu_z;
  logic               w_alu_c;
`ifdef CPU1_ILLEGAL_TRAP_EN
  logic               w_trap;
  logic               r_illegal;
`endif

  assign w_op  = r_ir[W +: OPC_W];
  assign w_imm = r_ir[OPND_LSB +: W];

  cpu1_alu #(.W(W)) u_alu (
    .i_op    (w_op),
    .i_acc   (r_acc),
    .i_imm   (w_imm),
    .i_z     (r_z),
    .i_c     (r_c),
    .o_acc_c (w_alu_acc),
    .o_z_c   (w_alu_z),
    .o_c_c   (w_alu_c)
  );

  // Sequencer state register; HALT is only left through reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= RESET_HALTED ? HALT : FETCH;
    else         r_state <= w_state_nxt;
  end

  // Next state and PC requests; PC requests exist only in EXEC
  always_comb begin
    w_state_nxt = r_state;
    w_ir_load   = 1'b0;
    w_pc_adv    = 1'b0;
    w_pc_jump   = 1'b0;
    w_pc_jump_v = '0;
`ifdef CPU1_ILLEGAL_TRAP_EN
    w_trap      = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        if (bus.run_i) begin
          w_ir_load   = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = FETCH;
        case (w_op)
          OP_NOP, OP_LDI, OP_ADDI, OP_SUBI, OP_OUT: w_pc_adv = 1'b1;
          OP_JMP: begin
            w_pc_jump   = 1'b1;
            w_pc_jump_v = w_imm;
          end
          OP_JZ: begin
            w_pc_jump   = r_z;
            w_pc_adv    = !r_z;
            w_pc_jump_v = r_z ? w_imm : '0;
          end
          OP_JC: begin
            w_pc_jump   = r_c;
            w_pc_adv    = !r_c;
            w_pc_jump_v = r_c ? w_imm : '0;
          end
          OP_HLT: w_state_nxt = HALT;
          default: begin
`ifdef CPU1_ILLEGAL_TRAP_EN
            w_trap      = 1'b1;
            w_state_nxt = HALT;
`else
            w_pc_adv    = 1'b1;
`endif
          end
        endcase
      end
      HALT: ;
      default: w_state_nxt = FETCH;
    endcase
  end

  // IR, accumulator, flags and output port; ALU passes state through for non-ALU opcodes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ir        <= '0;
      r_acc       <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_ir_load) r_ir <= bus.instr_i;
      if (r_state == EXEC) begin
        r_acc <= w_alu_acc;
        r_z   <= w_alu_z;
        r_c   <= w_alu_c;
        if (w_op == OP_OUT) begin
          r_out       <= r_acc;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

`ifdef CPU1_ILLEGAL_TRAP_EN
  // Sticky reserved-opcode indicator, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_illegal <= 1'b0;
    else if (w_trap) r_illegal <= 1'b1;
  end
  assign bus.illegal_o = r_illegal;
`else
  assign bus.illegal_o = 1'b0;
`endif

  assign bus.pc_adv_o    = w_pc_adv;
  assign bus.pc_jump_o   = w_pc_jump;
  assign bus.pc_jump_v_o = w_pc_jump_v;
  assign bus.acc_o       = r_acc;
  assign bus.z_o         = r_z;
  assign bus.c_o         = r_c;
  assign bus.out_o       = r_out;
  assign bus.out_valid_o = r_out_valid;
  assign bus.halted_o    = (r_state == HALT);
endmodule

// File: tb/tb_cpu1_ctrl.sv
// tb_cpu1_ctrl: directed + random instruction stream against an arithmetic reference model.
module tb_cpu1_ctrl;
  localparam int unsigned W  = 4;
  localparam int unsigned IW = W + 4;
  localparam int          MOD = 1 << W;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   trap_en;

  // Reference architectural state
  int m_acc, m_out;
  bit m_z, m_c, m_halted, m_illegal;

  cpu1_ctrl_if #(.W(W)) bus ();

  cpu1_ctrl #(.W(W), .RESET_HALTED(1'b0)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_out = 0; m_z = 0; m_c = 0; m_halted = 0; m_illegal = 0;
  endtask

  task automatic chk_arch(input string tag);
    chk({tag, "_acc"},    32'(bus.acc_o),     32'(m_acc));
    chk({tag, "_z"},      32'(bus.z_o),       32'(m_z));
    chk({tag, "_c"},      32'(bus.c_o),       32'(m_c));
    chk({tag, "_out"},    32'(bus.out_o),     32'(m_out));
    chk({tag, "_halted"}, 32'(bus.halted_o),  32'(m_halted));
    chk({tag, "_illegal"},32'(bus.illegal_o), 32'(m_illegal));
  endtask

  task automatic chk_no_pc(input string tag);
    chk({tag, "_adv"},  32'(bus.pc_adv_o),    32'd0);
    chk({tag, "_jump"}, 32'(bus.pc_jump_o),   32'd0);
    chk({tag, "_jv"},   32'(bus.pc_jump_v_o), 32'd0);
  endtask

  // Hold reset across a clock edge, check the cleared state, then release between edges
  task automatic do_reset();
    bus.run_i   = 1'b0;
    bus.instr_i = '0;
    rst_n       = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk_arch("rst");
    chk_no_pc("rst");
    chk("rst_outv", 32'(bus.out_valid_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One instruction: called in FETCH at posedge+1, returns after the EXEC->next edge
  task automatic exec_instr(input int unsigned op, input int unsigned imm);
    bit jump, adv;
    int s;
    bus.instr_i = IW'((op << W) | imm);
    bus.run_i   = 1'b1;
    @(posedge clk); #1;
    jump = (op == 4) || (op == 5 && m_z) || (op == 6 && m_c);
    adv  = !jump && (op != 8) && !(trap_en && op > 8);
    chk("exec_adv",  32'(bus.pc_adv_o),    32'(adv));
    chk("exec_jump", 32'(bus.pc_jump_o),   32'(jump));
    chk("exec_jv",   32'(bus.pc_jump_v_o), jump ? 32'(imm) : 32'd0);
    chk("exec_outv", 32'(bus.out_valid_o), 32'd0);
    case (op)
      1: begin m_acc = int'(imm); m_z = (m_acc == 0); end
      2: begin s = m_acc + int'(imm); m_c = (s >= MOD); m_acc = s % MOD; m_z = (m_acc == 0); end
      3: begin m_c = (int'(imm) > m_acc); m_acc = (m_acc + MOD - int'(imm)) % MOD; m_z = (m_acc == 0); end
      7: m_out = m_acc;
      8: m_halted = 1;
      default: if (trap_en && op > 8) begin m_halted = 1; m_illegal = 1; end
    endcase
    @(posedge clk); #1;
    chk_arch("post");
    chk_no_pc("post");
    chk("post_outv", 32'(bus.out_valid_o), 32'(op == 7));
  endtask

  // run_i low in FETCH with a changing instr_i: nothing may move
  task automatic stall(input int n);
    bus.run_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.instr_i = IW'($urandom);
      @(posedge clk); #1;
      chk_no_pc("stall");
      chk_arch("stall");
      chk("stall_outv", 32'(bus.out_valid_o), 32'd0);
    end
  endtask

  initial begin
`ifdef CPU1_ILLEGAL_TRAP_EN
    trap_en = 1'b1;
`else
    trap_en = 1'b0;
`endif
    bus.run_i   = 1'b0;
    bus.instr_i = '0;
    rst_n       = 1'b0;
    do_reset();

    // NOP stream: advance every second cycle, no jumps
    for (int i = 0; i < 4; i++) exec_instr(0, 0);

    // Arithmetic corners
    exec_instr(1, 9);
    exec_instr(2, 8);
    chk("addi_acc", 32'(bus.acc_o), 32'd1);
    chk("addi_c",   32'(bus.c_o),   32'd1);
    chk("addi_z",   32'(bus.z_o),   32'd0);
    exec_instr(3, 1);
    chk("subi_acc", 32'(bus.acc_o), 32'd0);
    chk("subi_z",   32'(bus.z_o),   32'd1);
    chk("subi_c",   32'(bus.c_o),   32'd0);
    exec_instr(3, 1);
    chk("wrap_acc", 32'(bus.acc_o), 32'd15);
    chk("wrap_c",   32'(bus.c_o),   32'd1);

    // Conditional jumps, taken and not taken
    exec_instr(1, 0);  exec_instr(5, 10);
    exec_instr(1, 1);  exec_instr(5, 10);
    exec_instr(1, 15); exec_instr(2, 1);  exec_instr(6, 10);
    exec_instr(1, 1);  exec_instr(2, 0);  exec_instr(6, 10);
    exec_instr(4, 3);

    // Output port pulse
    exec_instr(1, 5);
    exec_instr(7, 0);
    chk("out_val", 32'(bus.out_o), 32'd5);
    stall(1);

    stall(5);

    // Random legal (non-halting) stream with occasional stalls
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) stall(int'($urandom_range(1, 3)));
      exec_instr($urandom_range(0, 7), $urandom_range(0, 15));
    end

    // Asynchronous reset in the middle of an ADDI's EXEC cycle
    exec_instr(1, 3);
    bus.instr_i = IW'((2 << W) | 4);
    bus.run_i   = 1'b1;
    @(posedge clk); #1;
    chk("mid_adv", 32'(bus.pc_adv_o), 32'd1);
    #2;
    rst_n = 1'b0;
    bus.run_i = 1'b0;
    #1;
    model_reset();
    chk_arch("async");
    chk_no_pc("async");
    @(posedge clk); #1;
    chk("async_acc_hold", 32'(bus.acc_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reserved opcode
    exec_instr(1, 6);
    exec_instr(12, 7);
    if (trap_en) begin
      stall(3);
      do_reset();
    end else begin
      chk("rsv_acc", 32'(bus.acc_o), 32'd6);
    end

    // HLT is absorbing; run_i and instr_i ignored
    exec_instr(1, 5);
    exec_instr(8, 0);
    for (int i = 0; i < 20; i++) begin
      bus.run_i   = 1'($urandom);
      bus.instr_i = IW'($urandom);
      @(posedge clk); #1;
      chk_no_pc("halt");
      chk_arch("halt");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
